// File: rtl/clk_div_sequencer.sv
// Divided-clock controller: start/stop with a clean park-low, and ratio changes
// that take effect only on a falling edge of clk_out so no pulse is ever clipped.
module clk_div_sequencer #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pdiv_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic             busy_q;
    logic             err_q;

    logic accept;
    logic cfg_zero;
    logic at_end;

    assign accept    = cfg_valid & ~pend_q;
    assign cfg_zero  = (cfg_div == '0);
    assign at_end    = (cnt_q == div_q - CNT_W'(1));

    assign cfg_ready = ~pend_q;
    assign clk_out   = clk_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign cfg_err   = err_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            div_q   <= CNT_W'(DEFAULT_DIV);
            pdiv_q  <= '0;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            err_q  <= accept & cfg_zero;
            case (state_q)
                ST_STOP: begin
                    cnt_q <= '0;
                    clk_q <= 1'b0;
                    // A ratio left pending by the run that just ended lands here
                    if (pend_q) begin
                        div_q  <= pdiv_q;
                        pend_q <= 1'b0;
                    end else if (accept && !cfg_zero) begin
                        div_q <= cfg_div;
                    end
                    if (en) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    if (!en && !clk_q) begin
                        state_q <= ST_STOP;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (at_end) begin
                        cnt_q  <= '0;
                        clk_q  <= ~clk_q;
                        tick_q <= ~clk_q;
                        // Falling edge: the only safe point to swap ratio or park
                        if (clk_q && pend_q) begin
                            div_q  <= pdiv_q;
                            pend_q <= 1'b0;
                        end
                        if (clk_q && !en) begin
                            state_q <= ST_STOP;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= en ? ST_RUN : ST_DRAIN;
                        end
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= en ? ST_RUN : ST_DRAIN;
                    end
                    if (accept && !cfg_zero) begin
                        pdiv_q <= cfg_div;
                        pend_q <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
